// File: rtl/axi_mem_slave_pkg.sv
// Shared types and helpers for the AXI4 memory slave.
// Define AXI_MEM_SLAVE_WRAP_EN to support WRAP bursts; otherwise they are rejected with SLVERR.
package axi_mem_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

`ifdef AXI_MEM_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // The encoding already orders severity: DECERR > SLVERR > OKAY.
    function automatic resp_e worst_resp(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_mem_slave_addr_gen
    import axi_mem_slave_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step        = ADDR_W'(1) << size_i;
        aligned     = addr_i & ~(step - ADDR_W'(1));
        wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = aligned + step;
            BURST_WRAP: if (WRAP_EN) next_addr_o = (addr_i & ~wrap_mask) | ((aligned + step) & wrap_mask);
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent single-outstanding read and write engines over a byte-strobed RAM.
// WRAP bursts are honoured only when AXI_MEM_SLAVE_WRAP_EN is defined.
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awlock,
    input  logic [3:0]          awcache, awqos, awregion,
    input  logic [2:0]          awprot,
    input  logic [0:0]          awuser,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic [0:0]          wuser,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic [0:0]          buser,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arlock,
    input  logic [3:0]          arcache, arqos, arregion,
    input  logic [2:0]          arprot,
    input  logic [0:0]          aruser,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic [0:0]          ruser,
    output logic                rvalid,
    input  logic                rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = ADDR_W - OFFS_W;

    // Oversized beats, reserved bursts and illegal WRAP shapes fail every beat with SLVERR.
    function automatic logic cfg_err(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic misaligned, bad_len;
        misaligned = (addr & ((ADDR_W'(1) << size) - ADDR_W'(1))) != '0;
        bad_len    = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return (size > 3'(OFFS_W)) || (burst == 2'b11)
            || ((burst == BURST_WRAP) && (!WRAP_EN || misaligned || bad_len));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, w_next_addr;
    logic [7:0]        aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic              w_err_q, w_err_d, mem_we;
    resp_e             bresp_q, bresp_d, w_beat_resp;
    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, r_next_addr, r_beat_addr;
    logic [7:0]        ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic              r_err_q, r_err_d, r_beat_err, r_capture;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_e             rresp_q, rresp_d, r_beat_resp;
    logic              rlast_q, rlast_d;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;

    axi_mem_slave_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
        .addr_i(aw_addr_q), .len_i(aw_len_q), .size_i(aw_size_q), .burst_i(aw_burst_q),
        .next_addr_o(w_next_addr)
    );

    axi_mem_slave_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
        .addr_i(ar_addr_q), .len_i(ar_len_q), .size_i(ar_size_q), .burst_i(ar_burst_q),
        .next_addr_o(r_next_addr)
    );

    assign w_word = aw_addr_q[ADDR_W-1:OFFS_W];
    assign w_idx  = w_word[IDX_W-1:0];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        aw_burst_d  = aw_burst_q;
        w_err_d     = w_err_q;
        w_cnt_d     = w_cnt_q;
        bresp_d     = bresp_q;
        mem_we      = 1'b0;
        w_beat_resp = RESP_OKAY;
        if (w_err_q)                   w_beat_resp = RESP_SLVERR;
        if (w_word >= WORD_W'(DEPTH))  w_beat_resp = RESP_DECERR;
        case (w_state_q)
            W_IDLE: if (awvalid) begin
                aw_id_d    = awid;
                aw_addr_d  = awaddr;
                aw_len_d   = awlen;
                aw_size_d  = awsize;
                aw_burst_d = awburst;
                w_err_d    = cfg_err(awaddr, awlen, awsize, awburst);
                w_cnt_d    = 8'd0;
                bresp_d    = RESP_OKAY;
                w_state_d  = W_DATA;
            end
            W_DATA: if (wvalid) begin
                mem_we    = (w_beat_resp == RESP_OKAY);
                bresp_d   = worst_resp(bresp_q, w_beat_resp);
                if (wlast != (w_cnt_q == aw_len_q)) bresp_d = worst_resp(bresp_d, RESP_SLVERR);
                aw_addr_d = w_next_addr;
                w_cnt_d   = w_cnt_q + 8'd1;
                if (w_cnt_q == aw_len_q) w_state_d = W_RESP;
            end
            W_RESP:  if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // The first beat is captured straight from the AR inputs so rvalid follows the handshake by one cycle.
    assign r_beat_addr = (r_state_q == R_IDLE) ? araddr : r_next_addr;
    assign r_beat_err  = (r_state_q == R_IDLE) ? cfg_err(araddr, arlen, arsize, arburst) : r_err_q;
    assign r_word      = r_beat_addr[ADDR_W-1:OFFS_W];
    assign r_idx       = r_word[IDX_W-1:0];

    always_comb begin
        r_state_d   = r_state_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        r_err_d     = r_err_q;
        r_cnt_d     = r_cnt_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        r_capture   = 1'b0;
        r_beat_resp = RESP_OKAY;
        if (r_beat_err)                r_beat_resp = RESP_SLVERR;
        if (r_word >= WORD_W'(DEPTH))  r_beat_resp = RESP_DECERR;
        case (r_state_q)
            R_IDLE: if (arvalid) begin
                ar_id_d    = arid;
                ar_addr_d  = araddr;
                ar_len_d   = arlen;
                ar_size_d  = arsize;
                ar_burst_d = arburst;
                r_err_d    = r_beat_err;
                r_cnt_d    = 8'd0;
                rlast_d    = (arlen == 8'd0);
                r_capture  = 1'b1;
                r_state_d  = R_DATA;
            end
            R_DATA: if (rready) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    ar_addr_d = r_next_addr;
                    r_cnt_d   = r_cnt_q + 8'd1;
                    rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                    r_capture = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_capture) begin
            rdata_d = (r_beat_resp == RESP_OKAY) ? mem_q[r_idx] : '0;
            rresp_d = r_beat_resp;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_err_q    <= 1'b0;
            w_cnt_q    <= '0;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_err_q    <= 1'b0;
            r_cnt_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_err_q    <= w_err_d;
            w_cnt_q    <= w_cnt_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_err_q    <= r_err_d;
            r_cnt_q    <= r_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    // NOTE: the RAM has no reset on purpose; contents survive aresetn and map onto plain memory.
    always_ff @(posedge aclk) begin
        if (aresetn && mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign awready = aresetn && (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = aw_id_q;
    assign bresp   = bresp_q;
    assign buser   = '0;
    assign arready = aresetn && (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = ar_id_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign ruser   = '0;

    logic unused_sideband;
    assign unused_sideband = ^{awlock, awcache, awprot, awqos, awregion, awuser, wuser,
                               arlock, arcache, arprot, arqos, arregion, aruser};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed scoreboard bench for axi_mem_slave: stimulus pushes expected B/R responses, a monitor pops and compares.
module tb_axi_mem_slave;
    import axi_mem_slave_pkg::*;

    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, DEPTH = 256;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [ID_W-1:0] awid, arid, bid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awlock, arlock;
    logic [3:0] awcache, awqos, awregion, arcache, arqos, arregion;
    logic [0:0] awuser, aruser, wuser, buser, ruser;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;

    always #5 aclk = ~aclk;

    axi_mem_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awqos(awqos), .awregion(awregion), .awprot(awprot),
        .awuser(awuser), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arqos(arqos), .arregion(arregion), .arprot(arprot),
        .aruser(aruser), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic chk_data; } r_exp_t;

    b_exp_t exp_b[$];
    r_exp_t exp_r[$];
    b_exp_t eb;
    r_exp_t er;
    logic [31:0] wq[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample on the falling edge, where a valid&ready pair will complete at the next rising edge.
    always @(negedge aclk) begin
        if (aresetn && bvalid && bready) begin
            if (exp_b.size() == 0) check("b_unexpected", exp_b.size(), 1);
            else begin
                eb = exp_b.pop_front();
                check("bid", bid, eb.id);
                check("bresp", bresp, eb.resp);
            end
        end
        if (aresetn && rvalid && rready) begin
            if (exp_r.size() == 0) check("r_unexpected", exp_r.size(), 1);
            else begin
                er = exp_r.pop_front();
                check("rid", rid, er.id);
                if (er.chk_data) check("rdata", rdata, er.data);
                check("rresp", rresp, er.resp);
                check("rlast", rlast, er.last);
            end
        end
    end

    task automatic push_r(input logic [ID_W-1:0] id, input logic [31:0] data, input logic [1:0] resp,
                          input logic last, input logic chk_data);
        exp_r.push_back('{id, data, resp, last, chk_data});
    endtask

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        @(negedge aclk);
        while (!awready && n < 50) begin n++; @(negedge aclk); end
        check("awready_wait", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && n < 50) begin n++; @(negedge aclk); end
        check("arready_wait", arready, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin n++; @(negedge aclk); end
        check("drain", exp_b.size() + exp_r.size(), 0);
        @(posedge aclk); #1;
    endtask

    // Data beats come from wq; bad_last drops wlast on the final beat.
    task automatic write_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input logic bad_last, input logic [1:0] exp_resp);
        int n;
        exp_b.push_back('{id, exp_resp});
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wq[i]; wstrb = strb; wlast = bad_last ? 1'b0 : (i == int'(len)); wvalid = 1'b1;
            n = 0;
            @(negedge aclk);
            while (!wready && n < 50) begin n++; @(negedge aclk); end
            check("wready_wait", wready, 1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        drain();
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        ar_send(id, addr, len, size, burst);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        awlock = 1'b0; awcache = '0; awqos = '0; awregion = '0; awprot = '0; awuser = '0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        arlock = 1'b0; arcache = '0; arqos = '0; arregion = '0; arprot = '0; aruser = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", awready, 0); check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);   check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
        check("rst_bid", bid, 0);         check("rst_rid", rid, 0);
        check("rst_bresp", bresp, 0);     check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_awready", awready, 1); check("post_rst_arready", arready, 1);
        @(posedge aclk); #1;

        // Single write / read
        wq = '{32'hDEAD_BEEF};
        write_burst(4'h3, 32'h10, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_OKAY);
        push_r(4'h5, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h5, 32'h10, 8'd0, 3'd2, BURST_INCR);

        // INCR burst of four
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(4'h1, 32'h20, 8'd3, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_OKAY);
        push_r(4'h2, 32'd1, RESP_OKAY, 1'b0, 1'b1); push_r(4'h2, 32'd2, RESP_OKAY, 1'b0, 1'b1);
        push_r(4'h2, 32'd3, RESP_OKAY, 1'b0, 1'b1); push_r(4'h2, 32'd4, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h2, 32'h20, 8'd3, 3'd2, BURST_INCR);

        // Partial strobe over a cleared word
        wq = '{32'h0};
        write_burst(4'h4, 32'h0, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_OKAY);
        wq = '{32'hAABB_CCDD};
        write_burst(4'h4, 32'h0, 8'd0, 3'd2, BURST_INCR, 4'h5, 1'b0, RESP_OKAY);
        push_r(4'h6, 32'h00BB_00DD, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h6, 32'h0, 8'd0, 3'd2, BURST_INCR);

        // Decode errors: one past the end, and a burst crossing the end
        push_r(4'h7, 32'h0, RESP_DECERR, 1'b1, 1'b1);
        read_burst(4'h7, 32'h400, 8'd0, 3'd2, BURST_INCR);
        wq = '{32'h1234_5678};
        write_burst(4'h8, 32'h400, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_DECERR);
        wq = '{32'h3FC0_0001, 32'h3FC0_0002};
        write_burst(4'h8, 32'h3FC, 8'd1, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_DECERR);
        push_r(4'h8, 32'h3FC0_0001, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h8, 32'h3FC, 8'd0, 3'd2, BURST_INCR);

        // Oversized beat is rejected and leaves memory untouched
        wq = '{32'h1234_5678};
        write_burst(4'h9, 32'h10, 8'd0, 3'd3, BURST_INCR, 4'hF, 1'b0, RESP_SLVERR);
        push_r(4'h9, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h9, 32'h10, 8'd0, 3'd2, BURST_INCR);

        // WRAP: preload 0x30..0x3C, illegal length, then a legal wrap at 0x38
        wq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        write_burst(4'h1, 32'h30, 8'd3, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_OKAY);
        wq = '{32'hC0, 32'hC1, 32'hC2};
        write_burst(4'h3, 32'h30, 8'd2, 3'd2, BURST_WRAP, 4'hF, 1'b0, RESP_SLVERR);
        wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
`ifdef AXI_MEM_SLAVE_WRAP_EN
        write_burst(4'h2, 32'h38, 8'd3, 3'd2, BURST_WRAP, 4'hF, 1'b0, RESP_OKAY);
        push_r(4'hA, 32'hA2, RESP_OKAY, 1'b0, 1'b1); push_r(4'hA, 32'hA3, RESP_OKAY, 1'b0, 1'b1);
        push_r(4'hA, 32'hA0, RESP_OKAY, 1'b0, 1'b1); push_r(4'hA, 32'hA1, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'hA, 32'h30, 8'd3, 3'd2, BURST_INCR);
        push_r(4'hB, 32'hA0, RESP_OKAY, 1'b0, 1'b1); push_r(4'hB, 32'hA1, RESP_OKAY, 1'b0, 1'b1);
        push_r(4'hB, 32'hA2, RESP_OKAY, 1'b0, 1'b1); push_r(4'hB, 32'hA3, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'hB, 32'h38, 8'd3, 3'd2, BURST_WRAP);
`else
        write_burst(4'h2, 32'h38, 8'd3, 3'd2, BURST_WRAP, 4'hF, 1'b0, RESP_SLVERR);
        push_r(4'hA, 32'hB0, RESP_OKAY, 1'b0, 1'b1); push_r(4'hA, 32'hB1, RESP_OKAY, 1'b0, 1'b1);
        push_r(4'hA, 32'hB2, RESP_OKAY, 1'b0, 1'b1); push_r(4'hA, 32'hB3, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'hA, 32'h30, 8'd3, 3'd2, BURST_INCR);
        push_r(4'hB, 32'h0, RESP_SLVERR, 1'b0, 1'b0); push_r(4'hB, 32'h0, RESP_SLVERR, 1'b0, 1'b0);
        push_r(4'hB, 32'h0, RESP_SLVERR, 1'b0, 1'b0); push_r(4'hB, 32'h0, RESP_SLVERR, 1'b1, 1'b0);
        read_burst(4'hB, 32'h38, 8'd3, 3'd2, BURST_WRAP);
`endif

        // FIXED burst keeps hitting the same word
        wq = '{32'h11, 32'h22};
        write_burst(4'h5, 32'h40, 8'd1, 3'd2, BURST_FIXED, 4'hF, 1'b0, RESP_OKAY);
        push_r(4'h5, 32'h22, RESP_OKAY, 1'b0, 1'b1); push_r(4'h5, 32'h22, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h5, 32'h40, 8'd1, 3'd2, BURST_FIXED);

        // Missing wlast on the final beat
        wq = '{32'h55};
        write_burst(4'h6, 32'h50, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b1, RESP_SLVERR);

        // Read backpressure: the first beat must hold while rready is low
        wq = '{32'h600, 32'h601};
        write_burst(4'h7, 32'h60, 8'd1, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_OKAY);
        rready = 1'b0;
        ar_send(4'hC, 32'h60, 8'd1, 3'd2, BURST_INCR);
        repeat (5) begin
            @(negedge aclk);
            check("bp_rvalid", rvalid, 1); check("bp_rdata", rdata, 32'h600);
            check("bp_rlast", rlast, 0);   check("bp_rresp", rresp, RESP_OKAY);
        end
        push_r(4'hC, 32'h600, RESP_OKAY, 1'b0, 1'b1); push_r(4'hC, 32'h601, RESP_OKAY, 1'b1, 1'b1);
        @(posedge aclk); #1;
        rready = 1'b1;
        drain();

        // Reset with a read and a write burst both in flight
        rready = 1'b0;
        ar_send(4'hD, 32'h20, 8'd3, 3'd2, BURST_INCR);
        aw_send(4'hE, 32'h70, 8'd3, 3'd2, BURST_INCR);
        wdata = 32'h70; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(negedge aclk);
        check("mid_wready", wready, 1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("mid_rst_rvalid", rvalid, 0); check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_wready", wready, 0); check("mid_rst_rlast", rlast, 0);
        check("mid_rst_awready", awready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        rready = 1'b1;
        wq = '{32'hCAFE_0080};
        write_burst(4'hF, 32'h80, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, RESP_OKAY);
        push_r(4'h1, 32'hCAFE_0080, RESP_OKAY, 1'b1, 1'b1);
        read_burst(4'h1, 32'h80, 8'd0, 3'd2, BURST_INCR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width, a power of two in the range 32..128.
REQ-004 SHALL have parameter DEPTH, default 256, memory depth in DATA_W words.
REQ-005 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have ports awid/awaddr/awlen/awsize/awburst, input, ID_W/ADDR_W/8/3/2, write address.
REQ-008 SHALL have ports awvalid input 1 and awready output 1, write address handshake.
REQ-009 SHALL have ports wdata/wstrb/wlast/wvalid, input, DATA_W/DATA_W/8/1/1, write data.
REQ-010 SHALL have port wready, output, 1, write data ready.
REQ-011 SHALL have ports bid/bresp/bvalid, output, ID_W/2/1, and bready, input, 1, write response.
REQ-012 SHALL have ports arid/araddr/arlen/arsize/arburst/arvalid, input, read address, widths as for AW, and arready, output, 1.
REQ-013 SHALL have ports rid/rdata/rresp/rlast/rvalid, output, ID_W/DATA_W/2/1/1, and rready, input, 1, read data.
REQ-014 SHALL accept the ports a/ar{lock,cache,prot,qos,region,user}, wuser, buser and ruser at standard widths; inputs are ignored and buser/ruser are driven 0.

Function
REQ-015 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready = 1 only in W_IDLE, wready = 1 only in W_DATA, bvalid = 1 only in W_RESP.
REQ-016 An AW handshake in cycle N SHALL latch id/addr/len/size/burst and enter W_DATA, so wready is high in cycle N+1.
REQ-017 Each W beat SHALL write the bytes enabled by wstrb to mem[word index]; the burst SHALL end on beat count == awlen, and B SHALL be valid in the next cycle.
REQ-018 bvalid and bid SHALL hold until bready; the bready handshake SHALL return the FSM to W_IDLE.
REQ-019 Read FSM SHALL have states R_IDLE and R_DATA; arready = 1 only in R_IDLE; an AR handshake in cycle N SHALL give the first rvalid in cycle N+1.
REQ-020 rdata/rresp/rlast SHALL be stable while rvalid && !rready; rlast SHALL be 1 on beat arlen; the final handshake SHALL return the FSM to R_IDLE.
REQ-021 Read and write channels SHALL run independently, with one outstanding transaction each.
REQ-022 Word index SHALL be addr >> log2(DATA_W/8).
REQ-023 For a FIXED burst the address SHALL stay constant.
REQ-024 For an INCR burst the address SHALL advance by 2^size per beat, unaligned start aligned after the first beat.
REQ-025 An index >= DEPTH SHALL give DECERR (2'b11) for that beat, suppress the write and return rdata 0.
REQ-026 size > log2(DATA_W/8) SHALL give SLVERR (2'b10) on all beats and suppress writes.
REQ-027 bresp SHALL be the worst response of any beat, ordered DECERR > SLVERR > OKAY.
REQ-028 A wlast mismatch (wlast != (count == awlen)) on any beat SHALL force bresp to at least SLVERR.
REQ-029 The read beat SHALL be captured the cycle after the AR handshake or after the previous R handshake; a read and a write to the same word in one cycle SHALL return the pre-write data.

Reset
REQ-030 With aresetn = 0 at an aclk edge, both FSMs SHALL go to IDLE; awready/arready = 0 during reset and 1 from the first cycle after release.
REQ-031 During reset wready/bvalid/rvalid/rlast SHALL be 0, and bid/rid/bresp/rresp/rdata SHALL be 0.
REQ-032 Reset mid-burst SHALL abandon the burst with no response; memory contents are not reset.

Configuration
REQ-033 With AXI_MEM_SLAVE_WRAP_EN defined, a WRAP burst SHALL wrap at a boundary of (len+1)*2^size; it is legal only for len in {1,3,7,15} with an aligned start, otherwise SLVERR.
REQ-034 Without AXI_MEM_SLAVE_WRAP_EN, WRAP and reserved (2'b11) bursts SHALL give SLVERR on all beats, with writes suppressed.

Structure
REQ-035 Package axi_mem_slave_pkg SHALL hold the burst_e (FIXED/INCR/WRAP), resp_e (OKAY/EXOKAY/SLVERR/DECERR), w_state_e and r_state_e typedefs.
REQ-036 Sub-module axi_mem_slave_addr_gen SHALL be purely combinational (next address from addr/len/size/burst) and SHALL be instantiated once each for write and read.

Verification
REQ-037 Single write: awaddr=0x10, len=0, size=2, wdata=0xDEADBEEF, wstrb=0xF -> bresp=OKAY, bid=awid; a later read of 0x10 -> 0xDEADBEEF with rlast=1.
REQ-038 INCR write: len=3 at 0x20, data 1..4 -> reading 0x20..0x2C returns 1,2,3,4 with rlast on beat 4 only.
REQ-039 Partial strobe: write 0xAABBCCDD with wstrb=0x5 over 0 -> read returns 0x00BB00DD.
REQ-040 Address errors: araddr=DEPTH*4 -> rresp=DECERR, rdata=0; awsize=3 with DATA_W=32 -> bresp=SLVERR and memory unchanged.
REQ-041 WRAP burst: len=3, start 0x38 -> with the macro, beats go to 0x38, 0x3C, 0x30, 0x34; without it -> SLVERR.
REQ-042 Backpressure and reset: hold rready=0 for 5 cycles -> R stable; assert aresetn=0 mid-burst -> all valids 0 next cycle and a new transaction completes.
